// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// legal byte-enable patterns and default geometry.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_MEM_DEPTH  = 1024;
  localparam int BE_LANES           = 4;

  // Naturally aligned byte, halfword and word enables
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF0, BE_HALF1, BE_WORD: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage split into per-lane arrays: synchronous byte-enabled write
// port and a registered read port. Contents are never reset.
module data_mem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [BE_LANES-1:0]   wr_be,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int LANE_W = DATA_WIDTH / BE_LANES;

  for (genvar gi = 0; gi < BE_LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] lane_mem [MEM_DEPTH];
    logic [LANE_W-1:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*LANE_W +: LANE_W];
      end
      if (rd_en) begin
        lane_rd_reg <= lane_mem[rd_idx];
      end
    end

    assign rd_data[gi*LANE_W +: LANE_W] = lane_rd_reg;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: req/gnt handshake, WAIT_CYCLES
// wait states, one-cycle rvalid pulse. Define DMEM_ALIGN_CHECK_EN to reject
// byte enables that are not naturally aligned byte/halfword/word patterns.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam int WIDX_WIDTH = ADDR_WIDTH - 2;
  localparam logic [WIDX_WIDTH-1:0] DEPTH_LIMIT = WIDX_WIDTH'(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    we_reg;
  logic [WIDX_WIDTH-1:0]   widx_reg;
  logic [3:0]              be_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    err_reg, wr_reg;
  logic                    accept, enter_resp;

  logic                    op_we;
  logic [WIDX_WIDTH-1:0]   op_widx;
  logic [3:0]              op_be;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic                    op_err;
  logic                    mem_wr_en, mem_rd_en;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    addr_lsb_unused;

  assign addr_lsb_unused = ^addr_i[1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt_o      = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the RESP edge is the accept edge, so the live
  // request is used instead of the captured copy.
  always_comb begin
    if (state_reg == IDLE) begin
      op_we    = we_i;
      op_widx  = addr_i[ADDR_WIDTH-1:2];
      op_be    = be_i;
      op_wdata = wdata_i;
    end else begin
      op_we    = we_reg;
      op_widx  = widx_reg;
      op_be    = be_reg;
      op_wdata = wdata_reg;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign op_err = (op_widx >= DEPTH_LIMIT) || !be_is_legal(op_be);
`else
  assign op_err = (op_widx >= DEPTH_LIMIT);
`endif

  assign mem_wr_en = enter_resp && op_we && !op_err && !rst;
  assign mem_rd_en = enter_resp && !rst;

  data_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_be   (op_be),
    .wr_idx  (op_widx[IDX_WIDTH-1:0]),
    .wr_data (op_wdata),
    .rd_en   (mem_rd_en),
    .rd_idx  (op_widx[IDX_WIDTH-1:0]),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      widx_reg  <= '0;
      be_reg    <= 4'd0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= we_i;
        widx_reg  <= addr_i[ADDR_WIDTH-1:2];
        be_reg    <= be_i;
        wdata_reg <= wdata_i;
      end
      if (enter_resp) begin
        err_reg <= op_err;
        wr_reg  <= op_we;
      end
    end
  end

  assign rvalid_o = (state_reg == RESP);
  assign err_o    = rvalid_o && err_reg;
  assign rdata_o  = (rvalid_o && !err_reg && !wr_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: three responders (1, 3 and 0 wait states)
// checked against a word-array model of memory and response timing.
module tb_data_mem_responder;

  localparam int MEM_DEPTH = 1024;
  localparam int NDUT      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [NDUT];
  logic        req_s    [NDUT];
  logic        gnt_s    [NDUT];
  logic        we_s     [NDUT];
  logic [31:0] addr_s   [NDUT];
  logic [3:0]  be_s     [NDUT];
  logic [31:0] wdata_s  [NDUT];
  logic        rvalid_s [NDUT];
  logic [31:0] rdata_s  [NDUT];
  logic        err_s    [NDUT];

  int          waits [NDUT] = '{1, 3, 0};
  logic [31:0] mdl   [NDUT][MEM_DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  data_mem_responder #(.WAIT_CYCLES(1)) d_w1 (
    .clk(clk), .rst(rst_s[0]), .req_i(req_s[0]), .gnt_o(gnt_s[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .be_i(be_s[0]), .wdata_i(wdata_s[0]),
    .rvalid_o(rvalid_s[0]), .rdata_o(rdata_s[0]), .err_o(err_s[0]));

  data_mem_responder #(.WAIT_CYCLES(3)) d_w3 (
    .clk(clk), .rst(rst_s[1]), .req_i(req_s[1]), .gnt_o(gnt_s[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .be_i(be_s[1]), .wdata_i(wdata_s[1]),
    .rvalid_o(rvalid_s[1]), .rdata_o(rdata_s[1]), .err_o(err_s[1]));

  data_mem_responder #(.WAIT_CYCLES(0)) d_w0 (
    .clk(clk), .rst(rst_s[2]), .req_i(req_s[2]), .gnt_o(gnt_s[2]), .we_i(we_s[2]),
    .addr_i(addr_s[2]), .be_i(be_s[2]), .wdata_i(wdata_s[2]),
    .rvalid_o(rvalid_s[2]), .rdata_o(rdata_s[2]), .err_o(err_s[2]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic be_ok(input logic [3:0] be);
`ifdef DMEM_ALIGN_CHECK_EN
    return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
           (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
`else
    return 1'b1;
`endif
  endfunction

  // One complete transfer on responder k, checked against the model.
  task automatic xfer(input int k, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int          lat;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    idx     = int'(addr[31:2]);
    exp_err = (idx >= MEM_DEPTH) || !be_ok(be);
    if (we || exp_err) exp_rd = 32'h0;
    else               exp_rd = mdl[k][idx];

    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = we; addr_s[k] = addr; be_s[k] = be; wdata_s[k] = wd;
    #1 check_eq("gnt", 64'(gnt_s[k]), 64'(1'b1));
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_s[k] = 1'b0;
    end while (!rvalid_s[k] && lat < 40);
    rd = rdata_s[k];
    er = err_s[k];
    check_eq("rvalid_seen", 64'(rvalid_s[k]), 64'(1'b1));
    check_eq("latency", 64'(lat), 64'(1 + waits[k]));
    check_eq("err", 64'(er), 64'(exp_err));
    check_eq("rdata", 64'(rd), 64'(exp_rd));
    @(negedge clk);
    check_eq("rvalid_pulse", 64'(rvalid_s[k]), 64'(1'b0));

    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[k][idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    $display("xfer dut%0d %s addr=%h be=%b wd=%h -> rd=%h err=%b lat=%0d",
             k, we ? "WR" : "RD", addr, be, wd, rd, er, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] prior;
    logic        saw;
    int          idx;

    for (int k = 0; k < NDUT; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; we_s[k] = 1'b0;
      addr_s[k] = 32'h0; be_s[k] = 4'h0; wdata_s[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check_eq("rst_rvalid", 64'(rvalid_s[k]), 64'(1'b0));
      check_eq("rst_err", 64'(err_s[k]), 64'(1'b0));
      check_eq("rst_rdata", 64'(rdata_s[k]), 64'(32'h0));
      check_eq("rst_gnt", 64'(gnt_s[k]), 64'(1'b0));
    end
    for (int k = 0; k < NDUT; k++) rst_s[k] = 1'b0;

    // Give every word the bench touches a known value
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 16; w++) xfer(k, 1'b1, 32'(w * 4), 4'hF, $urandom, rd, er);
      xfer(k, 1'b1, 32'(1023 * 4), 4'hF, $urandom, rd, er);
    end

    // Read of 0x4 with one wait state: rvalid two cycles after grant
    xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, rd, er);
    check_eq("rd4_err", 64'(er), 64'(1'b0));

    // Partial-lane overwrite
    xfer(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er);
    xfer(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, rd, er);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check_eq("rmw_rdata", 64'(rd), 64'(32'hDEADBEAA));

    // Word index equal to depth
    xfer(0, 1'b0, 32'h1000, 4'b1111, 32'h0, rd, er);
    check_eq("oob_err", 64'(er), 64'(1'b1));
    check_eq("oob_rdata", 64'(rd), 64'(32'h0));
    xfer(0, 1'b1, 32'h1000, 4'b1111, 32'h12345678, rd, er);

    // be=0000 and misaligned enables
    xfer(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, er);
    xfer(0, 1'b1, 32'h20, 4'b0110, 32'h55AA55AA, rd, er);
    xfer(0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, er);

    // Reset during wait states aborts a write
    prior = mdl[1][12];
    saw   = 1'b0;
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h30; be_s[1] = 4'hF; wdata_s[1] = ~prior;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_s[1] = 1'b0;
      if (c == 3) rst_s[1] = 1'b1;
      if (c == 5) rst_s[1] = 1'b0;
      #1;
      if (rvalid_s[1]) saw = 1'b1;
      if (c == 3) begin
        check_eq("abort_rst_rvalid", 64'(rvalid_s[1]), 64'(1'b0));
        check_eq("abort_rst_rdata", 64'(rdata_s[1]), 64'(32'h0));
        check_eq("abort_rst_err", 64'(err_s[1]), 64'(1'b0));
      end
    end
    check_eq("abort_no_rvalid", 64'(saw), 64'(1'b0));
    xfer(1, 1'b0, 32'h30, 4'hF, 32'h0, rd, er);
    check_eq("abort_unchanged", 64'(rd), 64'(prior));

    // Back-to-back reads with zero wait states and req held high
    @(negedge clk);
    req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h8; be_s[2] = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("b2b_gnt", 64'(gnt_s[2]), 64'((c % 2) == 0));
      check_eq("b2b_rvalid", 64'(rvalid_s[2]), 64'((c % 2) == 1));
      if (rvalid_s[2]) check_eq("b2b_rdata", 64'(rdata_s[2]), 64'(mdl[2][2]));
      @(negedge clk);
    end
    req_s[2] = 1'b0;
    @(negedge clk);

    // Randomized traffic on every responder
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 8) idx = $urandom_range(0, 15);
        else                          idx = 1023 + $urandom_range(0, 3);
        xfer(k, 1'($urandom_range(0, 1)), 32'(idx * 4) | 32'($urandom_range(0, 3)),
             4'($urandom), $urandom, rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 The block SHALL expose parameter MEM_DEPTH, default 1024, storage depth in 32-bit words.
REQ-004 The block SHALL expose parameter WAIT_CYCLES, default 1, wait states inserted between accept and response (0..15).
REQ-005 The block SHALL run on one clock with asynchronous, active-high reset; port clk, input, 1, rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_i  input  1  initiator requests a transfer.
REQ-008 gnt_o  output  1  request accepted this cycle.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 addr_i  input  ADDR_WIDTH  byte address; word index = addr_i[ADDR_WIDTH-1:2].
REQ-011 be_i  input  4  byte enables, lane-accurate (bit n = byte lane n).
REQ-012 wdata_i  input  DATA_WIDTH  write data, lane-aligned.
REQ-013 rvalid_o  output  1  one-cycle response pulse (read data or write ack).
REQ-014 rdata_o  output  DATA_WIDTH  full read word; 0 for writes and errors.
REQ-015 err_o  output  1  error flag, valid only with rvalid_o.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 gnt_o SHALL equal req_i while in IDLE and 0 in WAIT and RESP (combinational).
REQ-018 On req_i && gnt_o, we_i, addr_i, be_i and wdata_i SHALL be registered; the FSM enters WAIT if WAIT_CYCLES > 0, else RESP.
REQ-019 WAIT SHALL count down a 4-bit counter loaded with WAIT_CYCLES-1 and enter RESP when it reaches 0.
REQ-020 A transfer accepted in cycle T SHALL produce rvalid_o=1 in cycle T+1+WAIT_CYCLES, for exactly one cycle.
REQ-021 Write data SHALL be committed to storage on the clock edge that enters RESP, writing only lanes with be=1.
REQ-022 Read data SHALL be the full stored word at the registered word index; lane selection and extension remain the initiator's job.
REQ-023 Word index >= MEM_DEPTH SHALL give err_o=1 and rdata_o=0, with no storage write.
REQ-024 RESP SHALL always return to IDLE; maximum throughput is one transfer per 2+WAIT_CYCLES cycles.
REQ-025 req_i changes while not in IDLE SHALL be ignored.
REQ-026 A read of a word written by the immediately preceding transfer SHALL return the new data.

Reset
REQ-027 rst SHALL force IDLE, counter=0, rvalid_o=0, err_o=0, rdata_o=0 and the captured request to 0.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Reset asserted in WAIT SHALL abort the transfer; no write is committed and no response is issued.

Configuration
REQ-030 With DMEM_ALIGN_CHECK_EN defined, be_i not in {0001,0010,0100,1000,0011,1100,1111} SHALL give err_o=1, rdata_o=0 and no write.
REQ-031 Without DMEM_ALIGN_CHECK_EN, any be_i SHALL be accepted; be_i=0000 writes nothing and acks with err_o=0.

Structure
REQ-032 Package dmem_pkg SHALL hold the FSM state enum, the legal byte-enable constants and the default width and depth constants.
REQ-033 Sub-module data_mem_array SHALL hold the storage: one synchronous write port with byte enables and one read port.

Verification
REQ-034 Reset, then read 0x00000004 with WAIT_CYCLES=1: gnt in T, rvalid in T+2, err_o=0.
REQ-035 Write 0xDEADBEEF, be=1111 to 0x10, then write 0x000000AA, be=0001 to 0x10, then read 0x10: rdata_o=0xDEADBEAA.
REQ-036 Read with word index = MEM_DEPTH (addr 0x1000 at default): rvalid_o=1, err_o=1, rdata_o=0.
REQ-037 With DMEM_ALIGN_CHECK_EN, write be=0110 to 0x20: err_o=1, and a following read of 0x20 returns the prior contents.
REQ-038 With WAIT_CYCLES=3, assert rst two cycles after accepting a write to 0x30: no rvalid_o, and 0x30 is unchanged.
REQ-039 With WAIT_CYCLES=0 and req_i held high: gnt_o toggles 1,0,1,0 and one rvalid_o follows each grant by one cycle.
